// File: rtl/inst_rom_resp.sv
// inst_rom_resp: instruction-memory responder on the fetch unit's ROM port.
// Word-organised synchronous array mapped at BASE_ADDR. Reads return a
// registered word after WAIT_CYCLES extra cycles. Byte-lane writes are used
// for boot-time loading.
//
// Ports:
//   clk             clock, all state on rising edge
//   rst             asynchronous active-low reset
//   rom_en          access request this cycle
//   rom_write_en    byte-lane write enables (0 = read)
//   rom_addr        byte address
//   rom_write_data  write data, lane i = bits 8i+7:8i
//   rom_read_data   registered read data
//   rom_data_valid  one-cycle pulse when rom_read_data is new
//   rom_stall_req   registered; requester holds its address while high
//   rom_addr_err    registered address error flag
//
// Optional feature: define INST_ROM_RANGE_CHECK_EN to flag out-of-range or
// misaligned reads and to drop out-of-range writes. Without it the index
// aliases modulo the depth and rom_addr_err is tied 0.
module inst_rom_resp #(
    parameter int                DATA_W      = 32,
    parameter int                ADDR_W      = 32,
    parameter int                DEPTH_LOG2  = 12,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'hbfc00000,
    parameter int                WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rom_en,
    input  logic [3:0]        rom_write_en,
    input  logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_write_data,
    output logic [DATA_W-1:0] rom_read_data,
    output logic              rom_data_valid,
    output logic              rom_stall_req,
    output logic              rom_addr_err
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    // Counter preload: the last WAIT cycle is the one that sees wcnt == 0.
    localparam logic [3:0] WLOAD = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

    typedef enum logic {IDLE, WAIT} state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t                state, state_d;
    logic [3:0]            wcnt, wcnt_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d;
    logic                  bad_q, bad_d;
    logic [DATA_W-1:0]     data_d;
    logic                  valid_d, stall_d, err_d;
    logic                  wr_fire;

    logic [ADDR_W-1:0]     offset;
    logic [DEPTH_LOG2-1:0] cur_idx, rd_idx;
    logic [DATA_W-1:0]     rd_word;
    logic                  rd_bad, wr_bad;
    logic                  rd_req, wr_req;
    logic                  unused_bits;

    assign offset  = rom_addr - BASE_ADDR;
    assign cur_idx = offset[DEPTH_LOG2+1:2];
    assign rd_req  = rom_en && (rom_write_en == 4'd0);
    assign wr_req  = rom_en && (rom_write_en != 4'd0);

`ifdef INST_ROM_RANGE_CHECK_EN
    assign rd_bad      = (|offset[ADDR_W-1:DEPTH_LOG2+2]) | (|rom_addr[1:0]);
    assign wr_bad      = |offset[ADDR_W-1:DEPTH_LOG2+2];
    assign unused_bits = ^offset[1:0];
`else
    assign rd_bad      = 1'b0;
    assign wr_bad      = 1'b0;
    assign unused_bits = ^{offset[ADDR_W-1:DEPTH_LOG2+2], offset[1:0]};
`endif

    // Single read port: the latched index while waiting, the live one otherwise.
    assign rd_idx  = (state == WAIT) ? idx_q : cur_idx;
    assign rd_word = mem[rd_idx];

    always_comb begin
        state_d = state;
        wcnt_d  = wcnt;
        idx_d   = idx_q;
        bad_d   = bad_q;
        data_d  = rom_read_data;
        valid_d = 1'b0;
        stall_d = rom_stall_req;
        err_d   = rom_addr_err;
        wr_fire = 1'b0;
        case (state)
            IDLE: begin
                if (rd_req) begin
                    if (WAIT_CYCLES == 0) begin
                        data_d  = rd_bad ? '0 : rd_word;
                        valid_d = 1'b1;
                        err_d   = rd_bad;
                    end else begin
                        idx_d   = cur_idx;
                        bad_d   = rd_bad;
                        wcnt_d  = WLOAD;
                        stall_d = 1'b1;
                        state_d = WAIT;
                    end
                end else if (wr_req) begin
                    wr_fire = !wr_bad;
                    err_d   = wr_bad;
                end
            end
            WAIT: begin
                // Inputs are ignored here; the requester is stalled.
                if (wcnt != 4'd0) begin
                    wcnt_d = wcnt - 4'd1;
                end else begin
                    data_d  = bad_q ? '0 : rd_word;
                    valid_d = 1'b1;
                    stall_d = 1'b0;
                    err_d   = bad_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            wcnt           <= 4'd0;
            idx_q          <= '0;
            bad_q          <= 1'b0;
            rom_read_data  <= '0;
            rom_data_valid <= 1'b0;
            rom_stall_req  <= 1'b0;
            rom_addr_err   <= 1'b0;
        end else begin
            state          <= state_d;
            wcnt           <= wcnt_d;
            idx_q          <= idx_d;
            bad_q          <= bad_d;
            rom_read_data  <= data_d;
            rom_data_valid <= valid_d;
            rom_stall_req  <= stall_d;
            rom_addr_err   <= err_d;
        end
    end

    // Array is not reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int i = 0; i < 4; i++) begin
                if (rom_write_en[i]) mem[cur_idx][8*i +: 8] <= rom_write_data[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_inst_rom_resp.sv
// Bench for inst_rom_resp: u0 has no wait states, u1 has three. Expected
// read results are queued when a read is driven and compared (data, error
// flag and cycle of arrival) when the DUT pulses rom_data_valid.
module tb_inst_rom_resp;
    localparam logic [31:0] B = 32'hbfc00000;

    typedef struct {
        logic [31:0] d;
        logic        e;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        en0 = 0, en1 = 0;
    logic [3:0]  we0 = 0, we1 = 0;
    logic [31:0] addr0 = 0, addr1 = 0, wd0 = 0, wd1 = 0;
    logic [31:0] rd0, rd1;
    logic        valid0, valid1, stall0, stall1, err0, err1;

    inst_rom_resp #(.WAIT_CYCLES(0)) u0 (
        .clk(clk), .rst(rst), .rom_en(en0), .rom_write_en(we0), .rom_addr(addr0),
        .rom_write_data(wd0), .rom_read_data(rd0), .rom_data_valid(valid0),
        .rom_stall_req(stall0), .rom_addr_err(err0)
    );
    inst_rom_resp #(.WAIT_CYCLES(3)) u1 (
        .clk(clk), .rst(rst), .rom_en(en1), .rom_write_en(we1), .rom_addr(addr1),
        .rom_write_data(wd1), .rom_read_data(rd1), .rom_data_valid(valid1),
        .rom_stall_req(stall1), .rom_addr_err(err1)
    );

    int   cmp_cnt = 0;
    int   err_cnt = 0;
    int   cyc = 0;
    logic stall0_seen = 1'b0;
    exp_t q0[$];
    exp_t q1[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        cmp_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (stall0) stall0_seen = 1'b1;
            if (valid0) begin
                if (q0.size() == 0) chk("u0_unexp_valid", 1, 0);
                else begin
                    e = q0.pop_front();
                    chk("u0_data", rd0, e.d);
                    chk("u0_err", err0, e.e);
                    chk("u0_lat", cyc, e.due);
                end
            end
            if (valid1) begin
                if (q1.size() == 0) chk("u1_unexp_valid", 1, 0);
                else begin
                    e = q1.pop_front();
                    chk("u1_data", rd1, e.d);
                    chk("u1_err", err1, e.e);
                    chk("u1_lat", cyc, e.due);
                end
            end
        end
    end

    task automatic drive(input int k, input logic e, input logic [3:0] w,
                         input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        if (k == 0) begin en0 = e; we0 = w; addr0 = a; wd0 = d; end
        else        begin en1 = e; we1 = w; addr1 = a; wd1 = d; end
    endtask

    task automatic wr(input int k, input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
        drive(k, 1'b1, w, a, d);
    endtask

    task automatic rd(input int k, input logic [31:0] a, input logic [31:0] d, input logic e);
        exp_t x;
        drive(k, 1'b1, 4'd0, a, 32'd0);
        x.d = d; x.e = e; x.due = cyc + 1 + ((k == 0) ? 0 : 3);
        if (k == 0) q0.push_back(x); else q1.push_back(x);
    endtask

    task automatic idle(input int k);
        drive(k, 1'b0, 4'd0, 32'd0, 32'd0);
    endtask

    task automatic drain(input int k);
        int n = 0;
        while (((k == 0) ? q0.size() : q1.size()) != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk((k == 0) ? "u0_drain" : "u1_drain", (k == 0) ? q0.size() : q1.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_u0_data", rd0, 0);   chk("rst_u0_valid", valid0, 0);
        chk("rst_u0_stall", stall0, 0); chk("rst_u0_err", err0, 0);
        chk("rst_u1_data", rd1, 0);   chk("rst_u1_valid", valid1, 0);
        chk("rst_u1_stall", stall1, 0); chk("rst_u1_err", err1, 0);
        rst = 1'b1;

        // Read-after-write, no wait states
        wr(0, B, 32'hdeadbeef, 4'hf);
        rd(0, B, 32'hdeadbeef, 1'b0);
        idle(0);
        drain(0);

        // Write leaves read data untouched
        wr(0, B + 4, 32'h11223344, 4'hf);
        idle(0);
        chk("u0_hold_data", rd0, 32'hdeadbeef);
        chk("u0_hold_valid", valid0, 0);

        // Byte lanes, then streaming reads
        wr(0, B + 4, 32'haabbccdd, 4'b0101);
        wr(0, B + 8, 32'h55667788, 4'hf);
        rd(0, B + 4, 32'h11bb33dd, 1'b0);
        rd(0, B,     32'hdeadbeef, 1'b0);
        rd(0, B + 4, 32'h11bb33dd, 1'b0);
        rd(0, B + 8, 32'h55667788, 1'b0);
        idle(0);
        drain(0);

        // Out-of-range and misaligned
`ifdef INST_ROM_RANGE_CHECK_EN
        rd(0, 32'hbfc04000, 32'h0, 1'b1);
        rd(0, 32'hbfc00002, 32'h0, 1'b1);
        rd(0, B + 8, 32'h55667788, 1'b0);
        idle(0);
        drain(0);
        wr(0, 32'hbfc04000, 32'hcafef00d, 4'hf);
        idle(0);
        chk("u0_wr_oob_err", err0, 1);
        rd(0, B, 32'hdeadbeef, 1'b0);
        idle(0);
        drain(0);
`else
        rd(0, 32'hbfc04000, 32'hdeadbeef, 1'b0);
        rd(0, 32'hbfc00002, 32'hdeadbeef, 1'b0);
        idle(0);
        drain(0);
        wr(0, 32'hbfc04000, 32'hcafef00d, 4'hf);
        rd(0, B, 32'hcafef00d, 1'b0);
        idle(0);
        drain(0);
`endif

        // Wait states: stall window, address change and write ignored
        wr(1, B + 16, 32'h0badc0de, 4'hf);
        rd(1, B + 16, 32'h0badc0de, 1'b0);
        drive(1, 1'b1, 4'd0, B, 32'd0);
        chk("u1_stall_t1", stall1, 1);
        chk("u1_valid_t1", valid1, 0);
        drive(1, 1'b1, 4'hf, B + 16, 32'hffffffff);
        chk("u1_stall_t2", stall1, 1);
        idle(1);
        chk("u1_stall_t3", stall1, 1);
        @(negedge clk);
        chk("u1_stall_t4", stall1, 0);
        drain(1);
        rd(1, B + 16, 32'h0badc0de, 1'b0);
        idle(1);
        drain(1);

        // Reset during WAIT: transaction dropped, stall clears at once
        drive(1, 1'b1, 4'd0, B + 16, 32'd0);
        idle(1);
        chk("u1_pre_rst_stall", stall1, 1);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("u1_rst_stall", stall1, 0);
        chk("u1_rst_valid", valid1, 0);
        chk("u1_rst_data", rd1, 0);
        @(negedge clk);
        rst = 1'b1;
        rd(1, B + 16, 32'h0badc0de, 1'b0);
        idle(1);
        drain(1);

        chk("u0_stall_never", stall0_seen, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule

// File: doc/inst_rom_resp.md
# inst_rom_resp

Instruction-memory responder at the far end of the fetch unit's ROM port. Samples `rom_en`/`rom_addr`/`rom_write_en`/`rom_write_data` from the program-counter stage, returns instruction words from a word-organised synchronous array mapped at the reset vector, and supports byte-lane writes for boot-time loading. Optional wait states model slow boot memory; they are signalled back as a registered stall request that the fetch unit routes into its PC stall input.

## Interface
- `DATA_W`, 32, instruction/data word width
- `ADDR_W`, 32, byte address width
- `DEPTH_LOG2`, 12, log2 of word count (4096 words = 16 KiB)
- `BASE_ADDR`, 32'hbfc00000, byte address of word 0
- `WAIT_CYCLES`, 0, extra read latency cycles (0..15)

Ports:
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `rom_en`  in  1  access request this cycle
- `rom_write_en`  in  4  byte-lane write enables; 0 = read
- `rom_addr`  in  ADDR_W  byte address
- `rom_write_data`  in  DATA_W  write data, lane i = bits 8i+7:8i
- `rom_read_data`  out  DATA_W  registered read data
- `rom_data_valid`  out  1  one-cycle pulse: `rom_read_data` is new this cycle
- `rom_stall_req`  out  1  registered; requester must hold its address while high
- `rom_addr_err`  out  1  registered error flag, qualified as below

## Operation
- Offset = `rom_addr - BASE_ADDR` (ADDR_W-bit wrap); word index = offset[DEPTH_LOG2+1:2]; bits [1:0] never select lanes on reads.
- States: IDLE, WAIT. Counter `wcnt` 4 bits.
- IDLE, `rom_en`=1, `rom_write_en`=0 (read): latch index; if WAIT_CYCLES=0 stay IDLE and present data next cycle; else go WAIT, `wcnt`<=WAIT_CYCLES-1, `rom_stall_req`<=1.
- WAIT: inputs ignored (reads and writes). `wcnt`≠0 → decrement. `wcnt`=0 → load `rom_read_data` from latched index, pulse `rom_data_valid`, clear `rom_stall_req`, go IDLE.
- IDLE, `rom_en`=1, `rom_write_en`≠0 (write): enabled lanes written at that edge; no wait states; `rom_stall_req` stays 0; `rom_data_valid` stays 0; `rom_read_data` holds.
- `rom_en`=0 in IDLE: no access; outputs hold except `rom_data_valid`=0.
- Back-to-back reads with WAIT_CYCLES=0: one word per cycle, each pulse valid.
- Array contents not reset; uninitialised reads return whatever the array holds.

## Timing
- Reset (async assert): `rom_read_data`=0, `rom_data_valid`=0, `rom_stall_req`=0, `rom_addr_err`=0, state IDLE, `wcnt`=0. Release takes effect at the next edge.
- Read accepted at edge T: data/valid at T+1+WAIT_CYCLES; `rom_stall_req` high T+1 .. T+WAIT_CYCLES, low in the data cycle.
- Write accepted at edge T visible to a read accepted at T+1 (read-after-write, no bypass needed, no same-edge read).
- Reset mid-WAIT: transaction dropped, no valid pulse, stall cleared immediately.
- `rom_stall_req` never depends combinationally on inputs (the requester's address is a function of its stall input).

## Configuration
- `INST_ROM_RANGE_CHECK_EN` defined: read with offset ≥ 4·2^DEPTH_LOG2 or `rom_addr[1:0]`≠0 returns `rom_read_data`=0 with `rom_addr_err`=1 in the valid cycle; out-of-range write is dropped and `rom_addr_err`=1 for the cycle after the write edge; otherwise `rom_addr_err`=0 in every cycle where it is updated.
- Not defined: index taken modulo depth (aliasing), low bits ignored, `rom_addr_err` tied 0.

## Test plan
- Reset then WAIT_CYCLES=0, write 32'hdeadbeef (we=4'hf) at 32'hbfc00000, read same address next cycle → `rom_read_data`=32'hdeadbeef, valid pulse one cycle later, stall never high.
- Byte lanes: word at 32'hbfc00004 = 32'h11223344, write we=4'b0101 data 32'haabbccdd → read returns 32'h11bb33dd.
- WAIT_CYCLES=3: read at edge T → stall high T+1..T+3, data+valid at T+4; address changes during WAIT ignored.
- Streaming reads 32'hbfc00000, +4, +8 with WAIT_CYCLES=0 → three consecutive valid pulses in address order.
- With `INST_ROM_RANGE_CHECK_EN`, DEPTH_LOG2=12: read 32'hbfc04000 → data 0, `rom_addr_err`=1; read 32'hbfc00002 → err=1; without macro, 32'hbfc04000 returns word 0.
- Assert `rst` low during WAIT (WAIT_CYCLES=5) → stall drops asynchronously, no valid pulse, next read behaves normally.
